// File: rtl/farrow_pkg.sv
// Shared helpers for the Farrow phase accumulator: width calculations and
// the output beat layout at the default configuration.
package farrow_pkg;

    localparam int FRAC_BITS_DEF = 16;
    localparam int INT_BITS_DEF  = 2;
    localparam int NUM_CH_DEF    = 4;

    // Channel pointer width; a single channel still needs one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Width of an INT_BITS.FRAC_BITS unsigned step.
    function automatic int step_width(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    localparam int CH_W_DEF = ch_width(NUM_CH_DEF);

    // Beat presented to the polynomial evaluator (default widths).
    typedef struct packed {
        logic [CH_W_DEF-1:0]      ch;
        logic [FRAC_BITS_DEF-1:0] mu;
        logic [INT_BITS_DEF:0]    adv;
    } farrow_beat_t;

endpackage

// File: rtl/farrow_phase_step.sv
// Combinational phase advance: adds an INT.FRAC step to a pure fraction and
// splits the result into the wrapped fraction and the integer sample advance.
module farrow_phase_step #(
    parameter int FRAC_BITS = 16,
    parameter int INT_BITS  = 2
) (
    input  logic [FRAC_BITS-1:0]          acc,
    input  logic [INT_BITS+FRAC_BITS-1:0] step,
    output logic [FRAC_BITS-1:0]          frac_next,
    output logic [INT_BITS:0]             adv
);

    localparam int STEP_W = INT_BITS + FRAC_BITS;

    // One extra bit so acc=max and step=max still fits (advance 2^INT_BITS).
    logic [STEP_W:0] sum;

    assign sum       = {1'b0, step} + {{(INT_BITS + 1){1'b0}}, acc};
    assign frac_next = sum[FRAC_BITS-1:0];
    assign adv       = sum[STEP_W:FRAC_BITS];

endmodule

// File: rtl/farrow_phase_accumulator.sv
// Multi-channel fractional phase accumulator feeding the Farrow evaluator.
// Channels are serviced round-robin; each beat carries the channel, the
// interpolation fraction mu and the number of input samples to consume.
module farrow_phase_accumulator
    import farrow_pkg::*;
#(
    parameter int FRAC_BITS = 16,
    parameter int INT_BITS  = 2,
    parameter int NUM_CH    = 4,
    parameter logic [INT_BITS+FRAC_BITS-1:0] STEP_DEFAULT = '0,
    parameter logic [FRAC_BITS-1:0]          PHASE_INIT   = '0,
    localparam int STEP_W = step_width(INT_BITS, FRAC_BITS),
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 step_we,
    input  logic [CH_W-1:0]      step_ch,
    input  logic [STEP_W-1:0]    step_val,
    input  logic                 phase_sync,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_ch,
    output logic [FRAC_BITS-1:0] mu,
    output logic [INT_BITS:0]    adv
);

    typedef struct packed {
        logic [CH_W-1:0]      ch;
        logic [FRAC_BITS-1:0] mu;
        logic [INT_BITS:0]    adv;
    } beat_t;

    beat_t                beat_reg;
    logic                 out_valid_reg;
    logic [CH_W-1:0]      ch_reg;
    logic [CH_W-1:0]      ch_next;
    logic [FRAC_BITS-1:0] acc_reg  [NUM_CH];
    logic [STEP_W-1:0]    step_reg [NUM_CH];
    logic [FRAC_BITS-1:0] cur_acc;
    logic [STEP_W-1:0]    cur_step;
    logic [FRAC_BITS-1:0] frac_next;
    logic [INT_BITS:0]    adv_next;
    logic [NUM_CH-1:0]    ch_sel;
    logic [NUM_CH-1:0]    step_wr_sel;
    logic                 load;

    // A new beat is produced whenever the output slot is empty or being drained.
    assign load = en && (!out_valid_reg || out_ready);

    // Per-channel decode of the active pointer and of the step write target;
    // a target outside 0..NUM_CH-1 matches nothing and is dropped.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_dec
        assign ch_sel[gi]      = (ch_reg == CH_W'(gi));
        assign step_wr_sel[gi] = step_we && (step_ch == CH_W'(gi));
    end

    // Select the phase and step of the channel being serviced.
    always_comb begin
        cur_acc  = '0;
        cur_step = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel[i]) begin
                cur_acc  = acc_reg[i];
                cur_step = step_reg[i];
            end
        end
    end

    assign ch_next = (ch_reg == CH_W'(NUM_CH - 1)) ? '0 : ch_reg + 1'b1;

    farrow_phase_step #(
        .FRAC_BITS (FRAC_BITS),
        .INT_BITS  (INT_BITS)
    ) u_step (
        .acc       (cur_acc),
        .step      (cur_step),
        .frac_next (frac_next),
        .adv       (adv_next)
    );

    // Step registers; a write colliding with a load lands after the beat uses the old value.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                step_reg[i] <= STEP_DEFAULT;
            end else if (step_wr_sel[i]) begin
                step_reg[i] <= step_val;
            end
        end
    end

    // Phase registers: sync reloads every channel, a load advances only the active one.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                acc_reg[i] <= '0;
            end else if (phase_sync) begin
                acc_reg[i] <= PHASE_INIT;
            end else if (load && ch_sel[i]) begin
                acc_reg[i] <= frac_next;
            end
        end
    end

    // Channel pointer and output beat register with valid/ready handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_reg        <= '0;
            beat_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else if (phase_sync) begin
            ch_reg        <= '0;
            out_valid_reg <= 1'b0;
        end else if (load) begin
            ch_reg        <= ch_next;
            beat_reg.ch   <= ch_reg;
            beat_reg.mu   <= cur_acc;
            beat_reg.adv  <= adv_next;
            out_valid_reg <= 1'b1;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_ch    = beat_reg.ch;
    assign mu        = beat_reg.mu;
    assign adv       = beat_reg.adv;

endmodule

// File: tb/tb_farrow_phase_accumulator.sv
// Bench for the Farrow phase accumulator: a 4-channel instance checked every
// cycle against an arithmetic reference model, and a 1-channel instance
// checked against fixed expected sequences.
module tb_farrow_phase_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // 4-channel instance, PHASE_INIT = 0xFFFF
    logic        en = 1'b0, step_we = 1'b0, phase_sync = 1'b0, out_ready = 1'b0;
    logic [1:0]  step_ch = '0;
    logic [17:0] step_val = '0;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] mu;
    logic [2:0]  adv;

    // 1-channel instance, PHASE_INIT = 0
    logic        en_b = 1'b0, step_we_b = 1'b0, phase_sync_b = 1'b0, out_ready_b = 1'b0;
    logic [0:0]  step_ch_b = '0;
    logic [17:0] step_val_b = '0;
    logic        out_valid_b;
    logic [0:0]  out_ch_b;
    logic [15:0] mu_b;
    logic [2:0]  adv_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state for the 4-channel instance (plain integers).
    int unsigned m_ph[4];
    int unsigned m_st[4];
    int unsigned m_ch, m_valid, m_mu, m_adv, m_och;

    logic [15:0] b_mu_a  [4] = '{16'h0000, 16'h8000, 16'h0000, 16'h8000};
    logic [2:0]  b_adv_a [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
    logic [15:0] b_mu_b  [5] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000};
    logic [2:0]  b_adv_b [5] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd1};
    logic [17:0] steps4  [4] = '{18'h04000, 18'h08000, 18'h10000, 18'h00000};

    always #5 clk = ~clk;

    farrow_phase_accumulator #(
        .FRAC_BITS (16), .INT_BITS (2), .NUM_CH (4),
        .STEP_DEFAULT (18'h0), .PHASE_INIT (16'hFFFF)
    ) u_dut (
        .clk (clk), .rst (rst), .en (en), .step_we (step_we),
        .step_ch (step_ch), .step_val (step_val), .phase_sync (phase_sync),
        .out_valid (out_valid), .out_ready (out_ready), .out_ch (out_ch),
        .mu (mu), .adv (adv)
    );

    farrow_phase_accumulator #(
        .FRAC_BITS (16), .INT_BITS (2), .NUM_CH (1),
        .STEP_DEFAULT (18'h0), .PHASE_INIT (16'h0000)
    ) u_dut_1ch (
        .clk (clk), .rst (rst), .en (en_b), .step_we (step_we_b),
        .step_ch (step_ch_b), .step_val (step_val_b), .phase_sync (phase_sync_b),
        .out_valid (out_valid_b), .out_ready (out_ready_b), .out_ch (out_ch_b),
        .mu (mu_b), .adv (adv_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the reference model with the inputs about to be sampled.
    task automatic model_step();
        int unsigned total;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_ph[i] = 0;
                m_st[i] = 0;
            end
            m_ch = 0; m_valid = 0; m_mu = 0; m_adv = 0; m_och = 0;
        end else begin
            if (phase_sync) begin
                for (int i = 0; i < 4; i++) m_ph[i] = 16'hFFFF;
                m_ch    = 0;
                m_valid = 0;
            end else if (en && (m_valid == 0 || out_ready)) begin
                total       = m_ph[m_ch] + m_st[m_ch];
                m_mu        = m_ph[m_ch];
                m_adv       = total / 65536;
                m_ph[m_ch]  = total % 65536;
                m_och       = m_ch;
                m_valid     = 1;
                m_ch        = (m_ch + 1) % 4;
            end else if (m_valid != 0 && out_ready) begin
                m_valid = 0;
            end
            if (step_we) m_st[step_ch] = step_val;
        end
    endtask

    // One clock: predict, let the edge happen, compare the 4-channel outputs.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_eq("valid", {31'b0, out_valid}, m_valid);
        if (m_valid != 0) begin
            check_eq("mu", {16'b0, mu}, m_mu);
            check_eq("adv", {29'b0, adv}, m_adv);
            check_eq("ch", {30'b0, out_ch}, m_och);
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_mu", {16'b0, mu}, 32'd0);
        check_eq("rst_adv", {29'b0, adv}, 32'd0);
        check_eq("rst_ch", {30'b0, out_ch}, 32'd0);
        check_eq("rst_valid_1ch", {31'b0, out_valid_b}, 32'd0);

        // Single channel, step 0.5
        step_we_b = 1'b1; step_val_b = 18'h08000;
        tick();
        step_we_b = 1'b0; en_b = 1'b1; out_ready_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("1ch_half_mu", {16'b0, mu_b}, {16'b0, b_mu_a[i]});
            check_eq("1ch_half_adv", {29'b0, adv_b}, {29'b0, b_adv_a[i]});
            check_eq("1ch_half_ch", {31'b0, out_ch_b}, 32'd0);
        end

        // Single channel, step 1.25 after resync
        en_b = 1'b0; step_we_b = 1'b1; step_val_b = 18'h14000; phase_sync_b = 1'b1;
        tick();
        check_eq("1ch_sync_valid", {31'b0, out_valid_b}, 32'd0);
        step_we_b = 1'b0; phase_sync_b = 1'b0; en_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("1ch_125_mu", {16'b0, mu_b}, {16'b0, b_mu_b[i]});
            check_eq("1ch_125_adv", {29'b0, adv_b}, {29'b0, b_adv_b[i]});
        end
        en_b = 1'b0;

        // Four channels with distinct steps
        for (int c = 0; c < 4; c++) begin
            step_we = 1'b1; step_ch = 2'(c); step_val = steps4[c];
            tick();
        end
        step_we = 1'b0; en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_ch == 2'd3) begin
                check_eq("ch3_mu", {16'b0, mu}, 32'd0);
                check_eq("ch3_adv", {29'b0, adv}, 32'd0);
            end
        end

        // Backpressure mid-stream
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (6) tick();

        // Step write colliding with the active channel on a load cycle
        step_we = 1'b1; step_ch = 2'(m_ch); step_val = 18'h0C000;
        tick();
        step_we = 1'b0;
        repeat (8) tick();

        // Max step on ch0, then sync while a beat is stalled
        step_we = 1'b1; step_ch = 2'd0; step_val = 18'h3FFFF;
        tick();
        step_we = 1'b0; out_ready = 1'b0;
        tick();
        phase_sync = 1'b1;
        tick();
        check_eq("sync_valid", {31'b0, out_valid}, 32'd0);
        phase_sync = 1'b0; out_ready = 1'b1;
        tick();
        check_eq("max_ch", {30'b0, out_ch}, 32'd0);
        check_eq("max_mu", {16'b0, mu}, 32'h0000FFFF);
        check_eq("max_adv", {29'b0, adv}, 32'd4);
        repeat (4) tick();
        check_eq("max2_ch", {30'b0, out_ch}, 32'd0);
        check_eq("max2_mu", {16'b0, mu}, 32'h0000FFFE);
        check_eq("max2_adv", {29'b0, adv}, 32'd4);

        // Reset mid-stream: outputs cleared, steps back to default (0)
        rst = 1'b1;
        tick();
        check_eq("midrst_valid", {31'b0, out_valid}, 32'd0);
        check_eq("midrst_mu", {16'b0, mu}, 32'd0);
        check_eq("midrst_adv", {29'b0, adv}, 32'd0);
        check_eq("midrst_ch", {30'b0, out_ch}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("midrst_step_mu", {16'b0, mu}, 32'd0);
            check_eq("midrst_step_adv", {29'b0, adv}, 32'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            en         = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            step_we    = ($urandom_range(0, 2) == 0);
            step_ch    = 2'($urandom_range(0, 3));
            step_val   = 18'($urandom);
            phase_sync = ($urandom_range(0, 31) == 0);
            rst        = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
